cordic_atan2: RTL and testbench
===============================

Name: cordic_atan2

Overview:
- Vectoring-mode CORDIC; the inverse of the team's rotation-mode sin/cos CORDIC.
- Reads a (cos, sin) sample pair (x, y) from two 16-bit input FIFOs.
- Writes the 32-bit angle atan2(y, x) to an angle FIFO and the gain-compensated magnitude sqrt(x²+y²) to a 16-bit magnitude FIFO.
- Fixed-point format is Q14 throughout (1.0 = 16384, PI = 51471, PI/2 = 25735), so angle output can be fed straight back into the sin/cos block for round-trip checks.

Parameters:
- STAGES, 16: number of CORDIC micro-rotation stages; legal range 1..16.
- Arctan table: atan(2^-i) in Q14, i = 0..15, values 0x3243, 0x1DAC, 0x0FAD, 0x07F5, 0x03FE, 0x01FF, 0x00FF, 0x007F, 0x003F, 0x001F, 0x000F, 0x0007, 0x0003, 0x0001, 0, 0.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- x_rd_en  out  1  pop x FIFO.
- x_empty  in  1  x FIFO empty.
- x_dout  in  16  signed Q14 x (cos) sample, first-word-fall-through.
- y_rd_en  out  1  pop y FIFO.
- y_empty  in  1  y FIFO empty.
- y_dout  in  16  signed Q14 y (sin) sample, first-word-fall-through.
- ang_wr_en  out  1  push angle FIFO.
- ang_full  in  1  angle FIFO full.
- ang_din  out  32  signed Q14 angle in [-PI, PI], sign-extended.
- mag_wr_en  out  1  push magnitude FIFO.
- mag_full  in  1  magnitude FIFO full.
- mag_din  out  16  signed Q14 magnitude, saturated to 0..32767.

Behaviour:
- **Reset** (reset=0, async): all pipeline x/y/z/valid/zero registers are cleared. ang_din = 0, mag_din = 0, ang_wr_en = mag_wr_en = 0. The pipeline restarts empty on deassertion, and samples in flight are discarded.
- **Stall:** pipe_en = ~valid_out | (~ang_full & ~mag_full). When pipe_en = 0, every pipeline register holds its value.
- **Input read:**
  - rd = ~x_empty & ~y_empty & pipe_en.
  - x_rd_en = y_rd_en = rd. Both FIFOs always pop together; neither pops alone.
  - If one FIFO is empty, no read occurs and a bubble (valid = 0) enters the pipe.
- **Pre-rotation** (combinational on the input word):
  - Sign-extend x and y to 18 bits.
  - If x < 0: x0 = -x, y0 = -y; z0 = +PI if y >= 0, else -PI.
  - Otherwise: x0 = x, y0 = y, z0 = 0.
  - z is 18-bit signed.
  - zero_flag = (x == 0 & y == 0).
- **Stage k** (k = 0..STAGES-1), registered when pipe_en:
  - If y[k] >= 0: x += y>>>k, y -= x>>>k, z += table[k].
  - Else: x -= y>>>k, y += x>>>k, z -= table[k].
  - Shifts are arithmetic and use the stage-k input values, i.e. a simultaneous update.
  - valid and zero_flag shift along with the data.
- **Output stage** (one extra register stage after stage STAGES-1):
  - Magnitude: mag = (x_final * 0x26DD) >>> 14, using a 36-bit product. Saturate to 32767 if the result exceeds it; clamp to 0 if negative.
  - Angle wrap: if z > PI then z -= 2*PI (102943); if z < -PI then z += 2*PI.
  - If zero_flag: angle = 0 and mag = 0, overriding the CORDIC result.
  - ang_din = sign-extended z.
- **Latency:** a pair popped in cycle N is presented with write enable in cycle N + STAGES + 1 (17 for the default), provided there is no stall. Throughput is one pair per cycle.
- **Output write:**
  - ang_wr_en = mag_wr_en = valid_out & ~ang_full & ~mag_full.
  - The two outputs are always written in the same cycle and are never split.
  - Data is held stable while stalled.
- **Simultaneous events:**
  - Full deasserts in the same cycle the pipe is otherwise ready: write and new read occur together.
  - Full asserts in the same cycle as an output: no write and no read; data is held.

Test Plan:
1. Reset mid-stream (reset low while 8 samples are in flight) -> all write enables are 0 at once. After release, only samples read after release emerge.
2. Cardinal points, angle/mag tolerance ±8 LSB:
   - (16384, 0) -> ang 0, mag 16384.
   - (0, 16384) -> ang 25735, mag 16384.
   - (0, -16384) -> ang -25735.
   - (-16384, 0) -> |ang| = 51471 ±8, mag 16384.
3. Diagonals:
   - (11585, 11585) -> ang 12868 ±8, mag 16384 ±8.
   - (-11585, -11585) -> ang -38603 ±8.
4. Zero / saturation:
   - (0, 0) -> ang 0, mag 0 exactly.
   - (32767, 32767) -> mag 32767 (saturated).
5. Backpressure:
   - Stream 100 random pairs with ang_full toggled at random and independently of mag_full.
   - Required: output order is preserved; wr_en is never asserted while either output FIFO is full; both FIFOs receive exactly 100 entries; results match the golden C model.
6. Round trip:
   - 256 angles pass through the sin/cos CORDIC and then this block, on x/y FIFOs filled at uneven rates.
   - Required: recovered angle is within ±16 LSB of the input (mod 2*PI); mag is 9949·1.6468 ≈ 16384 ±16.

Source files
------------

// File: rtl/cordic_atan2.sv
// Vectoring-mode CORDIC: streams (x, y) Q14 pairs from two FWFT FIFOs and
// writes atan2(y, x) and the gain-compensated magnitude to two output FIFOs.
module cordic_atan2 #(
  parameter int unsigned STAGES = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        x_rd_en,
  input  logic        x_empty,
  input  logic [15:0] x_dout,
  output logic        y_rd_en,
  input  logic        y_empty,
  input  logic [15:0] y_dout,
  output logic        ang_wr_en,
  input  logic        ang_full,
  output logic [31:0] ang_din,
  output logic        mag_wr_en,
  input  logic        mag_full,
  output logic [15:0] mag_din
);

  localparam int unsigned W    = 18;
  localparam int unsigned PW   = 36;
  localparam int unsigned AW   = 32;
  localparam int unsigned MW   = 16;
  localparam int unsigned FRAC = 14;

  localparam logic signed [W-1:0]  PI       = 18'sd51471;
  localparam logic signed [W-1:0]  NEG_PI   = -18'sd51471;
  localparam logic signed [W-1:0]  TWO_PI   = 18'sd102943;
  localparam logic signed [PW-1:0] GAIN_INV = 36'sd9949;
  localparam logic signed [PW-1:0] MAG_MAX  = 36'sd32767;

  localparam logic signed [W-1:0] ATAN [16] = '{
    18'sd12867, 18'sd7596, 18'sd4013, 18'sd2037,
    18'sd1022,  18'sd511,  18'sd255,  18'sd127,
    18'sd63,    18'sd31,   18'sd15,   18'sd7,
    18'sd3,     18'sd1,    18'sd0,    18'sd0
  };

  logic                pipe_en;
  logic                rd;
  logic                valid_out;
  logic signed [W-1:0] x_ext, y_ext, x0, y0, z0;
  logic                zero0;

  logic signed [W-1:0] x_q [STAGES];
  logic signed [W-1:0] y_q [STAGES];
  logic signed [W-1:0] z_q [STAGES];
  logic signed [W-1:0] x_s [STAGES];
  logic signed [W-1:0] y_s [STAGES];
  logic signed [W-1:0] z_s [STAGES];
  logic signed [W-1:0] x_n [STAGES];
  logic signed [W-1:0] y_n [STAGES];
  logic signed [W-1:0] z_n [STAGES];
  logic [STAGES-1:0]   v_q, zf_q, v_n, zf_n;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] mag_w;
  logic [MW-1:0]        mag_c;
  logic signed [W-1:0]  z_last;
  logic signed [W-1:0]  ang_w;

  // Flow control: the pipe advances unless a finished result is blocked.
  always_comb begin
    pipe_en   = !valid_out || (!ang_full && !mag_full);
    rd        = !x_empty && !y_empty && pipe_en;
    x_rd_en   = rd;
    y_rd_en   = rd;
    ang_wr_en = valid_out && !ang_full && !mag_full;
    mag_wr_en = valid_out && !ang_full && !mag_full;
  end

  // Fold the left half-plane onto the right so the micro-rotations converge.
  always_comb begin
    x_ext = W'($signed(x_dout));
    y_ext = W'($signed(y_dout));
    zero0 = (x_dout == 16'h0) && (y_dout == 16'h0);
    if (x_ext[W-1]) begin
      x0 = -x_ext;
      y0 = -y_ext;
      z0 = y_ext[W-1] ? NEG_PI : PI;
    end else begin
      x0 = x_ext;
      y0 = y_ext;
      z0 = '0;
    end
  end

  // Micro-rotation k drives y toward zero and accumulates the angle in z.
  always_comb begin
    x_s[0] = x0;
    y_s[0] = y0;
    z_s[0] = z0;
    for (int k = 1; k < STAGES; k++) begin
      x_s[k] = x_q[k-1];
      y_s[k] = y_q[k-1];
      z_s[k] = z_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (!y_s[k][W-1]) begin
        x_n[k] = x_s[k] + (y_s[k] >>> k);
        y_n[k] = y_s[k] - (x_s[k] >>> k);
        z_n[k] = z_s[k] + ATAN[k];
      end else begin
        x_n[k] = x_s[k] - (y_s[k] >>> k);
        y_n[k] = y_s[k] + (x_s[k] >>> k);
        z_n[k] = z_s[k] - ATAN[k];
      end
    end
    v_n  = (v_q << 1)  | STAGES'(rd);
    zf_n = (zf_q << 1) | STAGES'(zero0);
  end

  // Stage registers, all frozen together during a stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
      end
      v_q  <= '0;
      zf_q <= '0;
    end else if (pipe_en) begin
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= x_n[k];
        y_q[k] <= y_n[k];
        z_q[k] <= z_n[k];
      end
      v_q  <= v_n;
      zf_q <= zf_n;
    end
  end

  // Gain compensation with saturation, and wrap of the angle into [-PI, PI].
  always_comb begin
    prod   = PW'(x_q[STAGES-1]) * GAIN_INV;
    mag_w  = prod >>> FRAC;
    if (mag_w > MAG_MAX) begin
      mag_c = 16'h7FFF;
    end else if (mag_w[PW-1]) begin
      mag_c = '0;
    end else begin
      mag_c = mag_w[MW-1:0];
    end
    z_last = z_q[STAGES-1];
    if (z_last > PI) begin
      ang_w = z_last - TWO_PI;
    end else if (z_last < NEG_PI) begin
      ang_w = z_last + TWO_PI;
    end else begin
      ang_w = z_last;
    end
    if (zf_q[STAGES-1]) begin
      ang_w = '0;
      mag_c = '0;
    end
  end

  // Output register holding the result until both FIFOs accept it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      ang_din   <= '0;
      mag_din   <= '0;
    end else if (pipe_en) begin
      valid_out <= v_q[STAGES-1];
      ang_din   <= AW'(ang_w);
      mag_din   <= mag_c;
    end
  end

endmodule

// File: tb/tb_cordic_atan2.sv
// Bench for cordic_atan2: FIFO models around the DUT, a table of reference
// points, hand-written stall/reset/latency sequences, and a real-arithmetic
// atan2/sqrt reference for random and round-trip streams.
module tb_cordic_atan2;

  localparam int unsigned STAGES = 16;
  localparam int LAT      = 17;
  localparam int PI_Q     = 51471;
  localparam int TWO_PI_Q = 102943;
  localparam int RND_TOL  = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        x_rd_en, y_rd_en, ang_wr_en, mag_wr_en;
  logic        x_empty, y_empty, ang_full, mag_full;
  logic [15:0] x_dout, y_dout, mag_din;
  logic [31:0] ang_din;

  always #5 clock = ~clock;

  cordic_atan2 #(.STAGES(STAGES)) dut (
    .clock     (clock),
    .reset     (reset),
    .x_rd_en   (x_rd_en),
    .x_empty   (x_empty),
    .x_dout    (x_dout),
    .y_rd_en   (y_rd_en),
    .y_empty   (y_empty),
    .y_dout    (y_dout),
    .ang_wr_en (ang_wr_en),
    .ang_full  (ang_full),
    .ang_din   (ang_din),
    .mag_wr_en (mag_wr_en),
    .mag_full  (mag_full),
    .mag_din   (mag_din)
  );

  typedef struct { int ang; int mag; } res_t;
  typedef struct { int x; int y; } pair_t;
  typedef struct {
    int x; int y; int ang; int mag; int atol; int mtol; string name;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  int    x_src[$], y_src[$], x_fifo[$], y_fifo[$];
  res_t  got[$];
  pair_t sent[$];
  int    pop_cyc[$], wr_cyc[$];
  int    ang_cnt = 0, mag_cnt = 0;
  int    x_rate = 100, y_rate = 100, full_mode = 0;
  vec_t  vecs [8];

  function automatic res_t model(int x, int y);
    res_t r;
    real  m;
    if (x == 0 && y == 0) begin
      r.ang = 0;
      r.mag = 0;
      return r;
    end
    r.ang = int'($atan2(real'(y), real'(x)) * 16384.0);
    m     = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    r.mag = (m > 32767.0) ? 32767 : int'(m);
    return r;
  endfunction

  task automatic check_val(string name, int act, int exp, int tol);
    n_cmp++;
    if (act - exp > tol || exp - act > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d +/-%0d", name, act, exp, tol);
    end
  endtask

  task automatic check_ang(string name, int act, int exp, int tol);
    int d = act - exp;
    while (d > PI_Q) d -= TWO_PI_Q;
    while (d < -PI_Q) d += TWO_PI_Q;
    n_cmp++;
    if (d > tol || d < -tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d +/-%0d (mod 2pi)", name, act, exp, tol);
    end
  endtask

  task automatic update_ports();
    x_empty = (x_fifo.size() == 0);
    y_empty = (y_fifo.size() == 0);
    x_dout  = (x_fifo.size() == 0) ? 16'h0 : 16'(x_fifo[0]);
    y_dout  = (y_fifo.size() == 0) ? 16'h0 : 16'(y_fifo[0]);
  endtask

  task automatic push_pair(int x, int y);
    pair_t p;
    p.x = x;
    p.y = y;
    x_src.push_back(x);
    y_src.push_back(y);
    sent.push_back(p);
  endtask

  task automatic rand_pair(output int x, output int y);
    longint r2;
    do begin
      x  = int'($urandom_range(0, 65535)) - 32768;
      y  = int'($urandom_range(0, 65535)) - 32768;
      r2 = longint'(x) * x + longint'(y) * y;
    end while (r2 < 64'sd16777216);
  endtask

  // One clock: observe handshakes at the falling edge, update FIFOs after the rising edge.
  task automatic step();
    bit pop;
    @(negedge clock);
    cyc++;
    if (x_rd_en || y_rd_en) begin
      n_cmp++;
      if (x_rd_en !== y_rd_en) begin
        n_bad++;
        $display("FAIL rd_pair: x_rd_en=%b y_rd_en=%b, required equal", x_rd_en, y_rd_en);
      end
    end
    if (ang_wr_en || mag_wr_en) begin
      n_cmp++;
      if (ang_wr_en !== mag_wr_en) begin
        n_bad++;
        $display("FAIL wr_pair: ang_wr_en=%b mag_wr_en=%b, required equal", ang_wr_en, mag_wr_en);
      end
    end
    if (ang_full || mag_full) begin
      n_cmp++;
      if (ang_wr_en || mag_wr_en) begin
        n_bad++;
        $display("FAIL wr_while_full: ang_wr_en=%b mag_wr_en=%b with ang_full=%b mag_full=%b, required 0",
                 ang_wr_en, mag_wr_en, ang_full, mag_full);
      end
    end
    pop = x_rd_en && y_rd_en;
    if (pop) pop_cyc.push_back(cyc);
    if (ang_wr_en) begin
      res_t r;
      r.ang = int'($signed(ang_din));
      r.mag = int'(mag_din);
      got.push_back(r);
      wr_cyc.push_back(cyc);
      ang_cnt++;
    end
    if (mag_wr_en) mag_cnt++;
    @(posedge clock);
    #1;
    if (pop && x_fifo.size() > 0) void'(x_fifo.pop_front());
    if (pop && y_fifo.size() > 0) void'(y_fifo.pop_front());
    if (x_src.size() > 0 && int'($urandom_range(0, 99)) < x_rate) x_fifo.push_back(x_src.pop_front());
    if (y_src.size() > 0 && int'($urandom_range(0, 99)) < y_rate) y_fifo.push_back(y_src.pop_front());
    if (full_mode == 0) begin
      ang_full = 1'b0;
      mag_full = 1'b0;
    end else if (full_mode == 1) begin
      ang_full = ($urandom_range(0, 3) == 0);
      mag_full = ($urandom_range(0, 3) == 0);
    end
    update_ports();
  endtask

  task automatic wait_got(int n, int budget, string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (got.size() < n) begin
      n_bad++;
      $display("FAIL %s timeout: %0d results, required %0d", name, got.size(), n);
    end
  endtask

  task automatic check_stream(string name, int tol);
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      res_t e;
      e = model(sent[i].x, sent[i].y);
      check_ang($sformatf("%s[%0d] ang", name, i), got[i].ang, e.ang, tol);
      check_val($sformatf("%s[%0d] mag", name, i), got[i].mag, e.mag, tol);
    end
  endtask

  task automatic clear_stream();
    got.delete();
    sent.delete();
    pop_cyc.delete();
    wr_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x, y, held_a, held_m;
    int theta [$];

    vecs[0] = '{x:16384,  y:0,      ang:0,      mag:16384, atol:8, mtol:8, name:"east"};
    vecs[1] = '{x:0,      y:16384,  ang:25735,  mag:16384, atol:8, mtol:8, name:"north"};
    vecs[2] = '{x:0,      y:-16384, ang:-25735, mag:16384, atol:8, mtol:8, name:"south"};
    vecs[3] = '{x:-16384, y:0,      ang:51471,  mag:16384, atol:8, mtol:8, name:"west"};
    vecs[4] = '{x:11585,  y:11585,  ang:12868,  mag:16384, atol:8, mtol:8, name:"diag_q1"};
    vecs[5] = '{x:-11585, y:-11585, ang:-38603, mag:16384, atol:8, mtol:8, name:"diag_q3"};
    vecs[6] = '{x:0,      y:0,      ang:0,      mag:0,     atol:0, mtol:0, name:"origin"};
    vecs[7] = '{x:32767,  y:32767,  ang:12868,  mag:32767, atol:8, mtol:0, name:"saturate"};

    reset    = 1'b0;
    ang_full = 1'b0;
    mag_full = 1'b0;
    update_ports();
    repeat (3) @(posedge clock);
    #1;
    check_val("reset ang_wr_en", int'(ang_wr_en), 0, 0);
    check_val("reset mag_wr_en", int'(mag_wr_en), 0, 0);
    check_val("reset ang_din", int'(ang_din), 0, 0);
    check_val("reset mag_din", int'(mag_din), 0, 0);
    reset = 1'b1;
    repeat (2) step();

    // Reference points, each fed through an otherwise empty pipe.
    for (int i = 0; i < 8; i++) begin
      clear_stream();
      push_pair(vecs[i].x, vecs[i].y);
      wait_got(1, 60, vecs[i].name);
      if (got.size() > 0) begin
        check_ang({vecs[i].name, " ang"}, got[0].ang, vecs[i].ang, vecs[i].atol);
        check_val({vecs[i].name, " mag"}, got[0].mag, vecs[i].mag, vecs[i].mtol);
      end
    end

    // Latency and back-to-back throughput.
    clear_stream();
    for (int i = 0; i < 5; i++) push_pair(5000 + 1000 * i, 3000 - 1500 * i);
    wait_got(5, 80, "latency");
    for (int i = 0; i < 5; i++) begin
      if (i < pop_cyc.size() && i < wr_cyc.size())
        check_val($sformatf("latency[%0d]", i), wr_cyc[i] - pop_cyc[i], LAT, 0);
    end
    if (wr_cyc.size() >= 5) check_val("throughput span", wr_cyc[4] - wr_cyc[0], 4, 0);
    check_stream("latency", RND_TOL);

    // Full asserted while a result waits: no write, no read, data held.
    clear_stream();
    full_mode = 2;
    ang_full  = 1'b0;
    mag_full  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rand_pair(x, y);
      push_pair(x, y);
    end
    wait_got(1, 60, "stall start");
    ang_full = 1'b1;
    #1;
    check_val("stall wr_en", int'(ang_wr_en), 0, 0);
    check_val("stall rd_en", int'(x_rd_en), 0, 0);
    held_a = int'(ang_din);
    held_m = int'(mag_din);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall ang held", int'(ang_din), held_a, 0);
      check_val("stall mag held", int'(mag_din), held_m, 0);
      check_val("stall rd held", int'(x_rd_en), 0, 0);
    end
    ang_full = 1'b0;
    #1;
    check_val("release wr_en", int'(ang_wr_en), 1, 0);
    check_val("release rd_en", int'(x_rd_en), 1, 0);
    full_mode = 0;
    wait_got(30, 200, "stall drain");
    check_stream("stall", RND_TOL);

    // Reset with eight samples in flight.
    clear_stream();
    for (int i = 0; i < 12; i++) begin
      rand_pair(x, y);
      push_pair(x, y);
    end
    wait_got(4, 80, "pre-reset");
    check_stream("pre-reset", RND_TOL);
    check_val("pre-reset wr_en", int'(ang_wr_en), 1, 0);
    reset = 1'b0;
    #1;
    check_val("mid-reset ang_wr_en", int'(ang_wr_en), 0, 0);
    check_val("mid-reset mag_wr_en", int'(mag_wr_en), 0, 0);
    check_val("mid-reset ang_din", int'(ang_din), 0, 0);
    check_val("mid-reset mag_din", int'(mag_din), 0, 0);
    repeat (3) step();
    reset = 1'b1;
    clear_stream();
    for (int i = 0; i < 3; i++) begin
      rand_pair(x, y);
      push_pair(x, y);
    end
    wait_got(3, 60, "post-reset");
    repeat (25) step();
    check_val("post-reset count", got.size(), 3, 0);
    check_stream("post-reset", RND_TOL);

    // Random stream with independent random backpressure on both outputs.
    clear_stream();
    ang_cnt   = 0;
    mag_cnt   = 0;
    full_mode = 1;
    for (int i = 0; i < 100; i++) begin
      rand_pair(x, y);
      push_pair(x, y);
    end
    wait_got(100, 3000, "backpressure");
    full_mode = 0;
    repeat (30) step();
    check_val("ang entries", ang_cnt, 100, 0);
    check_val("mag entries", mag_cnt, 100, 0);
    check_stream("random", RND_TOL);

    // Round trip of unit-circle points on unevenly filled input FIFOs.
    clear_stream();
    x_rate = 60;
    y_rate = 35;
    for (int i = 0; i < 256; i++) begin
      real th;
      int  t;
      t  = -PI_Q + 402 * i;
      th = real'(t) / 16384.0;
      theta.push_back(t);
      push_pair(int'(16384.0 * $cos(th)), int'(16384.0 * $sin(th)));
    end
    wait_got(256, 6000, "round trip");
    for (int i = 0; i < got.size() && i < 256; i++) begin
      check_ang($sformatf("trip[%0d] ang", i), got[i].ang, theta[i], 16);
      check_val($sformatf("trip[%0d] mag", i), got[i].mag, 16384, 16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
